// File: rtl/adc_avg_mc.sv
// ---------------------------------------------------------------------------
// adc_avg_mc -- multi-channel ADC averager
//
// Accepts time-interleaved samples tagged with a channel index and keeps
// independent accumulator state per channel. The averaging length is
// N = 2**L. L is latched at run time and clamped to MAX_LOG2. Each
// configuration runs either block (decimating) or moving averages.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   i_cfg_load    1-cycle pulse: latch i_log2_n/i_mode/i_round, clear all
//                 channel state (the sample in that cycle is dropped)
//   i_log2_n      log2 of averaging length (clamped to MAX_LOG2)
//   i_mode        0 = block average, 1 = moving average
//   i_round       1 = round half-up, 0 = truncate
//   i_strobe      sample valid (up to one per clk)
//   i_ch          channel of the current sample
//   i_inst_data   sample value (unsigned)
//   o_strobe      result valid, 1-cycle pulse
//   o_ch          channel of the result (held between strobes)
//   o_avg_data    averaged value (held between strobes)
//   o_ch_err      1-cycle pulse: a sample with i_ch >= NCH was dropped
//
// Handshake: strobe-only, there is no back-pressure. A sample is taken in
// every cycle where i_strobe=1, i_cfg_load=0 and i_ch < NCH. o_strobe
// rises exactly 2 clk after the strobe cycle of the sample that completes
// a result.
//
// Pipeline
//   stage 1: read the channel state and the history word that leaves the
//            window. State that stage 2 is writing for the same channel in
//            the same cycle is forwarded.
//   stage 2: update the sum/count/pointer/fill flag, then register the
//            result.
// ---------------------------------------------------------------------------
module adc_avg_mc #(
  parameter int DATA_NBIT = 12,
  parameter int NCH       = 4,
  parameter int CH_NBIT   = 2,
  parameter int MAX_LOG2  = 6
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_cfg_load,
  input  logic [$clog2(MAX_LOG2+1)-1:0]    i_log2_n,
  input  logic                             i_mode,
  input  logic                             i_round,
  input  logic                             i_strobe,
  input  logic [CH_NBIT-1:0]               i_ch,
  input  logic [DATA_NBIT-1:0]             i_inst_data,
  output logic                             o_strobe,
  output logic [CH_NBIT-1:0]               o_ch,
  output logic [DATA_NBIT-1:0]             o_avg_data,
  output logic                             o_ch_err
);

  localparam int AW    = DATA_NBIT + MAX_LOG2;
  localparam int DEPTH = 2 ** MAX_LOG2;
  localparam int LW    = $clog2(MAX_LOG2 + 1);

  // latched configuration
  logic [LW-1:0]          r_log2;
  logic                   r_mode;
  logic                   r_round;

  // per-channel state
  logic [AW-1:0]          r_sum  [NCH];
  logic [MAX_LOG2-1:0]    r_cnt  [NCH];
  logic [MAX_LOG2-1:0]    r_ptr  [NCH];
  logic                   r_fill [NCH];
  logic [DATA_NBIT-1:0]   r_hist [NCH][DEPTH];

  // stage-1 registers (inputs to stage 2)
  logic                   r_s1_valid;
  logic [CH_NBIT-1:0]     r_s1_ch;
  logic [DATA_NBIT-1:0]   r_s1_data;
  logic [AW-1:0]          r_s1_sum;
  logic [MAX_LOG2-1:0]    r_s1_cnt;
  logic [MAX_LOG2-1:0]    r_s1_ptr;
  logic                   r_s1_fill;
  logic [DATA_NBIT-1:0]   r_s1_old;

  // length helpers derived from the latched L
  logic [MAX_LOG2:0]      w_len;
  logic [MAX_LOG2-1:0]    w_len_m1;
  logic [AW-1:0]          w_half;

  // stage-1 combinational
  logic                   w_ch_ok;
  logic                   w_acc;
  logic                   w_fwd;
  logic [AW-1:0]          w_rd_sum;
  logic [MAX_LOG2-1:0]    w_rd_cnt;
  logic [MAX_LOG2-1:0]    w_rd_ptr;
  logic                   w_rd_fill;
  logic [MAX_LOG2-1:0]    w_old_addr;

  // stage-2 combinational
  logic                   w_last;
  logic                   w_emit;
  logic [AW-1:0]          w_data_ext;
  logic [AW-1:0]          w_nxt_sum;
  logic [MAX_LOG2-1:0]    w_nxt_cnt;
  logic [MAX_LOG2-1:0]    w_nxt_ptr;
  logic                   w_nxt_fill;
  logic [AW-1:0]          w_round_sum;
  logic [DATA_NBIT-1:0]   w_avg;

  assign w_len    = (MAX_LOG2+1)'(1) << r_log2;
  // The low MAX_LOG2 bits of 2**MAX_LOG2 are zero. Subtracting 1 in
  // MAX_LOG2 bits therefore still gives the correct last count.
  assign w_len_m1 = w_len[MAX_LOG2-1:0] - MAX_LOG2'(1);
  // This is 2**(L-1), and it is 0 when L = 0.
  assign w_half   = AW'(w_len >> 1);

  // ---------------- stage 1: channel check, state read, forwarding -------
  always_comb begin
    w_ch_ok = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (i_ch == CH_NBIT'(c)) w_ch_ok = 1'b1;
    end
  end

  assign w_acc = i_strobe && !i_cfg_load && w_ch_ok;
  assign w_fwd = r_s1_valid && (r_s1_ch == i_ch);

  assign w_rd_sum  = w_fwd ? w_nxt_sum  : r_sum[i_ch];
  assign w_rd_cnt  = w_fwd ? w_nxt_cnt  : r_cnt[i_ch];
  assign w_rd_ptr  = w_fwd ? w_nxt_ptr  : r_ptr[i_ch];
  assign w_rd_fill = w_fwd ? w_nxt_fill : r_fill[i_ch];

  // This is the word leaving the window, hist[ptr - 2**L]. Stage 2 can be
  // writing hist[ptr-1] in the same cycle. The two addresses coincide only
  // when L = 0, and stage 2 ignores the old word in that case.
  assign w_old_addr = w_rd_ptr - w_len[MAX_LOG2-1:0];

  // ---------------- stage 2: state update and result ---------------------
  assign w_last     = (r_s1_cnt == w_len_m1);
  assign w_data_ext = AW'(r_s1_data);

  always_comb begin
    w_nxt_sum  = r_s1_sum;
    w_nxt_cnt  = r_s1_cnt;
    w_nxt_ptr  = r_s1_ptr;
    w_nxt_fill = r_s1_fill;
    w_emit     = 1'b0;
    if (!r_mode) begin
      w_nxt_sum = (r_s1_cnt == '0) ? w_data_ext : r_s1_sum + w_data_ext;
      w_emit    = w_last;
      w_nxt_cnt = w_last ? '0 : r_s1_cnt + MAX_LOG2'(1);
    end else begin
      if (r_log2 == '0)
        w_nxt_sum = w_data_ext;
      else if (r_s1_fill)
        w_nxt_sum = r_s1_sum + w_data_ext - AW'(r_s1_old);
      else
        w_nxt_sum = r_s1_sum + w_data_ext;
      // During warm-up, the count tracks how many samples are in the window.
      // Once the window is full, every sample produces a result.
      w_emit     = r_s1_fill || w_last;
      w_nxt_fill = r_s1_fill || w_last;
      if (!w_emit) w_nxt_cnt = r_s1_cnt + MAX_LOG2'(1);
      w_nxt_ptr  = r_s1_ptr + MAX_LOG2'(1);
    end
  end

  // sum + 2**(L-1) stays below 2**AW for any legal N, so no carry is lost
  assign w_round_sum = w_nxt_sum + (r_round ? w_half : '0);
  assign w_avg       = DATA_NBIT'(w_round_sum >> r_log2);

  // ---------------- config, stage-1 registers, outputs -------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_log2     <= '0;
      r_mode     <= 1'b0;
      r_round    <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_ch    <= '0;
      r_s1_data  <= '0;
      r_s1_sum   <= '0;
      r_s1_cnt   <= '0;
      r_s1_ptr   <= '0;
      r_s1_fill  <= 1'b0;
      r_s1_old   <= '0;
      o_strobe   <= 1'b0;
      o_ch       <= '0;
      o_avg_data <= '0;
      o_ch_err   <= 1'b0;
    end else begin
      if (i_cfg_load) begin
        r_log2  <= (i_log2_n > LW'(MAX_LOG2)) ? LW'(MAX_LOG2) : i_log2_n;
        r_mode  <= i_mode;
        r_round <= i_round;
      end
      r_s1_valid <= w_acc;
      if (w_acc) begin
        r_s1_ch   <= i_ch;
        r_s1_data <= i_inst_data;
        r_s1_sum  <= w_rd_sum;
        r_s1_cnt  <= w_rd_cnt;
        r_s1_ptr  <= w_rd_ptr;
        r_s1_fill <= w_rd_fill;
        r_s1_old  <= r_hist[i_ch][w_old_addr];
      end
      // A result in stage 2 during a cfg-load cycle still completes. It uses
      // the old configuration because r_log2/r_mode/r_round update only at
      // the end of that cycle.
      o_strobe <= r_s1_valid && w_emit;
      if (r_s1_valid && w_emit) begin
        o_ch       <= r_s1_ch;
        o_avg_data <= w_avg;
      end
      o_ch_err <= i_strobe && !i_cfg_load && !w_ch_ok;
    end
  end

  // ---------------- per-channel state write-back -------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        r_sum[c]  <= '0;
        r_cnt[c]  <= '0;
        r_ptr[c]  <= '0;
        r_fill[c] <= 1'b0;
      end
    end else if (i_cfg_load) begin
      // A clear overrides the stage-2 write-back of the same cycle.
      for (int c = 0; c < NCH; c++) begin
        r_sum[c]  <= '0;
        r_cnt[c]  <= '0;
        r_ptr[c]  <= '0;
        r_fill[c] <= 1'b0;
      end
    end else if (r_s1_valid) begin
      r_sum[r_s1_ch]  <= w_nxt_sum;
      r_cnt[r_s1_ch]  <= w_nxt_cnt;
      r_ptr[r_s1_ch]  <= w_nxt_ptr;
      r_fill[r_s1_ch] <= w_nxt_fill;
    end
  end

  // History RAM. It needs no reset: the fill flags keep stale words out of
  // the sum.
  always_ff @(posedge clk) begin
    if (r_s1_valid && r_mode) r_hist[r_s1_ch][r_s1_ptr] <= r_s1_data;
  end

endmodule

// File: tb/tb_adc_avg_mc.sv
// ---------------------------------------------------------------------------
// tb_adc_avg_mc -- self-checking bench for adc_avg_mc (NCH=3, so that
// i_ch=3 is an illegal channel)
// ---------------------------------------------------------------------------
module tb_adc_avg_mc;

  localparam int DATA_NBIT = 12;
  localparam int NCH       = 3;
  localparam int CH_NBIT   = 2;
  localparam int MAX_LOG2  = 6;
  localparam int LW        = 3;
  localparam int EW        = 32 + CH_NBIT + DATA_NBIT;

  // ---------------- clock / reset ----------------
  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 i_cfg_load;
  logic [LW-1:0]        i_log2_n;
  logic                 i_mode;
  logic                 i_round;
  logic                 i_strobe;
  logic [CH_NBIT-1:0]   i_ch;
  logic [DATA_NBIT-1:0] i_inst_data;
  logic                 o_strobe;
  logic [CH_NBIT-1:0]   o_ch;
  logic [DATA_NBIT-1:0] o_avg_data;
  logic                 o_ch_err;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  adc_avg_mc #(
    .DATA_NBIT(DATA_NBIT), .NCH(NCH), .CH_NBIT(CH_NBIT), .MAX_LOG2(MAX_LOG2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_cfg_load(i_cfg_load), .i_log2_n(i_log2_n),
    .i_mode(i_mode), .i_round(i_round), .i_strobe(i_strobe), .i_ch(i_ch),
    .i_inst_data(i_inst_data), .o_strobe(o_strobe), .o_ch(o_ch),
    .o_avg_data(o_avg_data), .o_ch_err(o_ch_err)
  );

  // ---------------- scoreboard ----------------
  // Each entry is {cycle the result must appear, channel, value}.
  logic [EW-1:0] exp_q[$];
  int            err_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            hold_ch = 0;
  int            hold_d  = 0;

  // ---------------- vector table ----------------
  typedef struct {
    bit ld;
    bit mode;
    int log2;
    bit rnd;
    int ch;
    int data;
    bit ev;
    int ed;
  } vec_t;
  vec_t tbl[$];

  function automatic void add_cfg(input bit mode, input int log2, input bit rnd);
    vec_t v;
    v = '{ld: 1'b1, mode: mode, log2: log2, rnd: rnd, ch: 0, data: 0, ev: 1'b0, ed: 0};
    tbl.push_back(v);
  endfunction

  function automatic void add_smp(input int ch, input int data, input bit ev, input int ed);
    vec_t v;
    v = '{ld: 1'b0, mode: 1'b0, log2: 0, rnd: 1'b0, ch: ch, data: data, ev: ev, ed: ed};
    tbl.push_back(v);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input int ch, input int data, input bit ev, input int ed);
    @(negedge clk);
    i_cfg_load  = 1'b0;
    i_strobe    = 1'b1;
    i_ch        = CH_NBIT'(ch);
    i_inst_data = DATA_NBIT'(data);
    if (ev) exp_q.push_back({32'(cyc + 2), CH_NBIT'(ch), DATA_NBIT'(ed)});
  endtask

  task automatic send_err(input int ch, input int data);
    @(negedge clk);
    i_cfg_load  = 1'b0;
    i_strobe    = 1'b1;
    i_ch        = CH_NBIT'(ch);
    i_inst_data = DATA_NBIT'(data);
    err_q.push_back(cyc + 1);
  endtask

  task automatic load(input bit mode, input int log2, input bit rnd,
                      input bit stb, input int ch, input int data);
    @(negedge clk);
    i_cfg_load  = 1'b1;
    i_log2_n    = LW'(log2);
    i_mode      = mode;
    i_round     = rnd;
    i_strobe    = stb;
    i_ch        = CH_NBIT'(ch);
    i_inst_data = DATA_NBIT'(data);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_cfg_load = 1'b0;
      i_strobe   = 1'b0;
    end
  endtask

  task automatic chk(input string name, input int got, input int req);
    n_vec++;
    if (got != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // ---------------- output monitor ----------------
  task automatic monitor();
    logic [EW-1:0] e;
    int e_cyc, e_ch, e_d;
    bit err_due;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (o_strobe) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_strobe: got ch=%0d data=%0d at cyc %0d, required no strobe",
                     o_ch, o_avg_data, cyc);
          end else begin
            e = exp_q.pop_front();
            e_cyc = int'(e[EW-1 -: 32]);
            e_ch  = int'(e[CH_NBIT+DATA_NBIT-1 -: CH_NBIT]);
            e_d   = int'(e[DATA_NBIT-1:0]);
            hold_ch = e_ch;
            hold_d  = e_d;
            if (int'(o_ch) != e_ch || int'(o_avg_data) != e_d || cyc != e_cyc) begin
              n_err++;
              $display("FAIL result: got ch=%0d data=%0d cyc=%0d, required ch=%0d data=%0d cyc=%0d",
                       o_ch, o_avg_data, cyc, e_ch, e_d, e_cyc);
            end
          end
        end else begin
          n_vec++;
          if (int'(o_ch) != hold_ch || int'(o_avg_data) != hold_d) begin
            n_err++;
            $display("FAIL hold: got ch=%0d data=%0d, required ch=%0d data=%0d at cyc %0d",
                     o_ch, o_avg_data, hold_ch, hold_d, cyc);
          end
        end
        err_due = (err_q.size() != 0) && (err_q[0] == cyc);
        if (o_ch_err || err_due) begin
          n_vec++;
          if (!(o_ch_err && err_due)) begin
            n_err++;
            $display("FAIL ch_err: got %0d, required %0d at cyc %0d", o_ch_err, err_due, cyc);
          end
          if (err_due) void'(err_q.pop_front());
        end
      end
    end
  endtask

  // ---------------- test ----------------
  initial begin
    rst_n       = 1'b0;
    i_cfg_load  = 1'b0;
    i_log2_n    = '0;
    i_mode      = 1'b0;
    i_round     = 1'b0;
    i_strobe    = 1'b0;
    i_ch        = '0;
    i_inst_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_strobe", o_strobe, 0);
    chk("rst_ch", o_ch, 0);
    chk("rst_avg", o_avg_data, 0);
    chk("rst_ch_err", o_ch_err, 0);

    fork
      monitor();
    join_none

    // Table groups run back to back. Each cfg load lands while the last
    // result of the previous group is still in flight.
    add_cfg(1'b0, 2, 1'b0);                   // block L=2 truncate
    add_smp(0, 1, 0, 0); add_smp(0, 2, 0, 0); add_smp(0, 3, 0, 0); add_smp(0, 4, 1, 2);
    add_cfg(1'b0, 2, 1'b1);                   // block L=2 round: (10+2)>>2
    add_smp(0, 1, 0, 0); add_smp(0, 2, 0, 0); add_smp(0, 3, 0, 0); add_smp(0, 4, 1, 3);
    add_cfg(1'b1, 1, 1'b0);                   // moving L=1
    add_smp(2, 10, 0, 0); add_smp(2, 20, 1, 15); add_smp(2, 30, 1, 25); add_smp(2, 40, 1, 35);
    add_cfg(1'b0, 0, 1'b0);                   // block pass-through
    add_smp(1, 9, 1, 9); add_smp(0, 4095, 1, 4095); add_smp(2, 0, 1, 0);
    add_cfg(1'b1, 0, 1'b1);                   // moving pass-through
    add_smp(2, 100, 1, 100); add_smp(2, 7, 1, 7); add_smp(1, 4095, 1, 4095);
    add_cfg(1'b0, 1, 1'b1);                   // block L=1 round, interleaved
    add_smp(0, 3, 0, 0); add_smp(1, 4, 0, 0); add_smp(0, 4, 1, 4); add_smp(1, 5, 1, 5);
    add_cfg(1'b1, 2, 1'b1);                   // moving L=2 round, ch0 interleaved
    add_smp(1, 1, 0, 0); add_smp(1, 2, 0, 0); add_smp(0, 100, 0, 0); add_smp(1, 3, 0, 0);
    add_smp(1, 4, 1, 3); add_smp(1, 5, 1, 4); add_smp(1, 8, 1, 5);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].ld) load(tbl[i].mode, tbl[i].log2, tbl[i].rnd, 1'b0, 0, 0);
      else           send(tbl[i].ch, tbl[i].data, tbl[i].ev, tbl[i].ed);
    end
    idle(4);

    // ch0 4095 and ch1 0 interleaved every clk, block L=3
    load(1'b0, 3, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      send(i % 2, (i % 2 == 0) ? 4095 : 0, i >= 14, (i % 2 == 0) ? 4095 : 0);
    end
    idle(4);

    // Moving average with log2 = 7, which clamps to 6, over a ramp k = 0..69.
    // Once the window is full it holds k-63..k, so the sum is (2k-63)*32.
    load(1'b1, 7, 1'b0, 1'b0, 0, 0);
    for (int k = 0; k < 70; k++) begin
      send(1, k, k >= 63, ((2 * k - 63) * 32) >> 6);
    end
    idle(4);

    // Mid-block cfg load with a sample in the same cycle (dropped, no error),
    // followed by a fresh block of 8s.
    load(1'b0, 2, 1'b0, 1'b0, 0, 0);
    send(0, 50, 0, 0); send(0, 60, 0, 0);
    load(1'b0, 2, 1'b0, 1'b1, 0, 999);
    send(0, 8, 0, 0); send(0, 8, 0, 0); send(0, 8, 0, 0); send(0, 8, 1, 8);
    idle(4);

    // A pass-through result in flight across a cfg load to L=2
    load(1'b0, 0, 1'b0, 1'b0, 0, 0);
    send(1, 33, 1, 33);
    load(1'b0, 2, 1'b0, 1'b0, 0, 0);
    send(1, 5, 0, 0); send(1, 6, 0, 0); send(1, 7, 0, 0); send(1, 9, 1, 6);
    idle(4);

    // An illegal channel in the middle of a block leaves the block untouched.
    send(2, 1, 0, 0); send(2, 1, 0, 0);
    send_err(3, 4000);
    send(2, 1, 0, 0); send(2, 1, 1, 1);
    idle(4);

    // Reset in mid-block: outputs drop at once, then the cfg and state defaults
    // apply.
    send(0, 5, 0, 0); send(0, 6, 0, 0);
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_strobe", o_strobe, 0);
    chk("midrst_ch", o_ch, 0);
    chk("midrst_avg", o_avg_data, 0);
    chk("midrst_ch_err", o_ch_err, 0);
    hold_ch = 0;
    hold_d  = 0;
    exp_q.delete();
    err_q.delete();
    idle(2);
    #2 rst_n = 1'b1;
    send(1, 77, 1, 77);
    send(0, 6, 1, 6);
    idle(4);

    for (int i = 0; i < 50 && (exp_q.size() != 0 || err_q.size() != 0); i++) @(negedge clk);
    while (exp_q.size() != 0) begin
      logic [EW-1:0] e;
      e = exp_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing_result: got nothing, required ch=%0d data=%0d at cyc %0d",
               e[CH_NBIT+DATA_NBIT-1 -: CH_NBIT], e[DATA_NBIT-1:0], e[EW-1 -: 32]);
    end
    while (err_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL missing_ch_err: got nothing, required pulse at cyc %0d", err_q.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
